// File: rtl/cram_port_arbiter_if.sv
// Cart RAM arbiter bus bundle: CPU path, backup engine handshake and RAM port.
// master = surrounding system (mapper, backup engine, RAM); slave = arbiter.
interface cram_port_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 8
);
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_di;
  logic [DW-1:0] cpu_do;
  logic          bk_req;
  logic          bk_we;
  logic [AW-1:0] bk_addr;
  logic [DW-1:0] bk_di;
  logic [DW-1:0] bk_do;
  logic          bk_ack;
  logic          bk_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_di, bk_req, bk_we, bk_addr, bk_di, ram_q,
    input  cpu_do, bk_do, bk_ack, bk_busy, ram_addr, ram_we, ram_d
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_di, bk_req, bk_we, bk_addr, bk_di, ram_q,
    output cpu_do, bk_do, bk_ack, bk_busy, ram_addr, ram_we, ram_d
  );
endinterface

// File: rtl/cram_port_arbiter.sv
// Single-port cart RAM arbiter. The CPU path has fixed latency and always
// wins the port; the battery backup engine is slotted into idle cycles and
// retried whenever the CPU takes the slot it wanted. Tracks a dirty flag so
// autosave knows when the CPU has modified RAM.
module cram_port_arbiter #(
  parameter int AW = 17,
  parameter int DW = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic enable,
  input  logic ram_enabled,
  input  logic dirty_clr,
  output logic dirty,
  cram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU_RD, OWN_BK_RD} owner_t;

  state_t        state;
  owner_t        owner;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] d_q;
  logic          cpu_strobe;
  logic          cpu_we;
  logic          bk_slot;

  assign cpu_strobe = bus.cpu_rd | bus.cpu_wr;
  assign cpu_we     = bus.cpu_wr & ram_enabled & enable;
  // Backup engine only gets the port in ISSUE when the CPU is silent.
  assign bk_slot    = (state == ISSUE) & ~cpu_strobe;

  // RAM port mux: CPU first, then a pending backup access, else hold.
  always_comb begin
    bus.ram_addr = addr_q;
    bus.ram_d    = d_q;
    bus.ram_we   = 1'b0;
    if (cpu_strobe) begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_d    = bus.cpu_di;
      bus.ram_we   = cpu_we;
    end else if (state == ISSUE) begin
      bus.ram_addr = bus.bk_addr;
      bus.ram_d    = bus.bk_di;
      bus.ram_we   = bus.bk_we & enable;
    end
  end

  // Remember last driven address/data so idle cycles keep the port stable.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      d_q    <= '0;
    end else begin
      addr_q <= bus.ram_addr;
      d_q    <= bus.ram_d;
    end
  end

  // Record who issued this cycle's read so next cycle's ram_q is steered right.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                        owner <= OWN_NONE;
    else if (!enable)                    owner <= OWN_NONE;
    else if (bus.cpu_rd)                 owner <= OWN_CPU_RD;
    else if (bk_slot && !bus.bk_we)      owner <= OWN_BK_RD;
    else                                 owner <= OWN_NONE;
  end

  // CPU read data: capture ram_q one cycle after the strobe, hold otherwise.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                            bus.cpu_do <= '1;
    else if (enable && owner == OWN_CPU_RD)  bus.cpu_do <= bus.ram_q;
  end

  // Backup handshake FSM with registered ack/busy.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bus.bk_do   <= '0;
      bus.bk_ack  <= 1'b0;
      bus.bk_busy <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      bus.bk_ack  <= 1'b0;
      bus.bk_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.bk_ack <= 1'b0;
          if (bus.bk_req) begin
            state       <= ISSUE;
            bus.bk_busy <= 1'b1;
          end
        end
        ISSUE: begin
          if (!cpu_strobe) begin
            if (bus.bk_we) begin
              state      <= ACK;
              bus.bk_ack <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          state      <= ACK;
          bus.bk_ack <= 1'b1;
          if (owner == OWN_BK_RD) bus.bk_do <= bus.ram_q;
        end
        ACK: begin
          state       <= IDLE;
          bus.bk_ack  <= 1'b0;
          bus.bk_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Dirty flag: an effective CPU write beats a same-cycle clear.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       dirty <= 1'b0;
    else if (cpu_we)    dirty <= 1'b1;
    else if (dirty_clr) dirty <= 1'b0;
  end

endmodule

// File: tb/tb_cram_port_arbiter.sv
// Bench for cram_port_arbiter: directed corner cases then randomized CPU and
// backup traffic; expectations queued at issue time, checked by a monitor.
module tb_cram_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;

  logic clk_sys = 1'b0;
  logic reset_n, enable, ram_enabled, dirty_clr, dirty;

  cram_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  cram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .enable      (enable),
    .ram_enabled (ram_enabled),
    .dirty_clr   (dirty_clr),
    .dirty       (dirty),
    .bus         (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  // Physical RAM: synchronous write, 1-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_d;
    bus.ram_q <= mem[bus.ram_addr];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          model_dirty = 1'b0;
  logic [31:0]   bk_written = '0;
  bit            done = 0;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    int            start;
    int            lo;
    int            hi;
  } bk_exp_t;

  logic [DW-1:0] cpu_q [$];
  bk_exp_t       bk_q [$];
  int tests = 0, fails = 0;
  int cyc = 0;
  logic rd_d1, rd_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // CPU read data appears two edges after the strobe is sampled.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_d1 <= 1'b0;
      rd_d2 <= 1'b0;
    end else begin
      rd_d1 <= bus.cpu_rd & enable;
      rd_d2 <= rd_d1;
    end
  end

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk_sys) begin
    logic [DW-1:0] e;
    bk_exp_t b;
    int lat;
    if (rd_d2) begin
      if (cpu_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL cpu_do: data %0h with no read outstanding", bus.cpu_do);
      end else begin
        e = cpu_q.pop_front();
        chk("cpu_do", 32'(bus.cpu_do), 32'(e));
      end
    end
    if (bus.bk_ack) begin
      if (bk_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL bk_ack: ack %0b with no backup op outstanding", bus.bk_ack);
      end else begin
        b = bk_q.pop_front();
        lat = cyc - b.start;
        tests++;
        if (lat < b.lo || lat > b.hi) begin
          fails++;
          $display("FAIL bk_latency: got %0d expected %0d..%0d", lat, b.lo, b.hi);
        end
        if (!b.we) chk("bk_do", 32'(bus.bk_do), 32'(b.data));
        chk("bk_busy_at_ack", 32'(bus.bk_busy), 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_di = d;
    if (ram_enabled && enable) begin
      ref_mem[a]  = d;
      model_dirty = 1'b1;
    end
    step();
    bus.cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    bus.cpu_rd = 1'b1; bus.cpu_addr = a;
    if (enable) cpu_q.push_back(ref_mem[a]);
    step();
    bus.cpu_rd = 1'b0;
  endtask

  task automatic bk_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int lo, input int hi);
    bk_exp_t e;
    int n;
    bus.bk_req = 1'b1; bus.bk_we = we; bus.bk_addr = a; bus.bk_di = d;
    e.we = we; e.data = we ? d : ref_mem[a]; e.start = cyc; e.lo = lo; e.hi = hi;
    if (we) ref_mem[a] = d;
    bk_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!bus.bk_ack && n < 20);
    if (!bus.bk_ack) begin
      tests++; fails++;
      $display("FAIL bk_timeout: no ack after %0d cycles, addr %0h", n, a);
      void'(bk_q.pop_back());
    end
    step();
    bus.bk_req = 1'b0;
  endtask

  task automatic cpu_proc(input int n);
    int op;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      chk("dirty_rand", 32'(dirty), 32'(model_dirty));
      op = $urandom_range(0, 5);
      a = AW'($urandom_range(0, 63));
      ram_enabled = ($urandom_range(0, 3) != 0);
      dirty_clr = ($urandom_range(0, 7) == 0);
      if (dirty_clr) model_dirty = 1'b0;
      if (op < 2)      cpu_read(a);
      else if (op < 4) cpu_write(a, DW'($urandom));
      else             step();
      dirty_clr = 1'b0;
      if (op < 4) step();
    end
    done = 1;
  endtask

  task automatic bk_proc();
    int idx;
    logic we;
    while (!done) begin
      repeat ($urandom_range(0, 3)) step();
      if (done) break;
      idx = $urandom_range(0, 31);
      we = ($urandom_range(0, 1) == 1) || !bk_written[idx];
      bk_written[idx] = 1'b1;
      if (we) bk_op(1'b1, AW'(17'h10000 + idx), DW'($urandom), 2, 3);
      else    bk_op(1'b0, AW'(17'h10000 + idx), '0, 3, 4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit %0d reached", 500000);
    $fatal(1);
  end

  initial begin
    int acks;
    reset_n = 1'b0; enable = 1'b1; ram_enabled = 1'b1; dirty_clr = 1'b0;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_di = '0;
    bus.bk_req = 1'b0; bus.bk_we = 1'b0; bus.bk_addr = '0; bus.bk_di = '0;
    repeat (3) step();
    chk("rst_cpu_do",   32'(bus.cpu_do),   32'hFF);
    chk("rst_bk_do",    32'(bus.bk_do),    32'h0);
    chk("rst_bk_ack",   32'(bus.bk_ack),   32'h0);
    chk("rst_bk_busy",  32'(bus.bk_busy),  32'h0);
    chk("rst_dirty",    32'(dirty),        32'h0);
    chk("rst_ram_we",   32'(bus.ram_we),   32'h0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("rst_ram_d",    32'(bus.ram_d),    32'h0);
    reset_n = 1'b1;
    step();

    // Preload CPU region and conflict addresses.
    for (int a = 0; a < 64; a++) begin
      cpu_write(AW'(a), DW'($urandom));
      step();
    end
    cpu_write(17'h00100, 8'hA1); step();
    cpu_write(17'h00200, 8'hB2); step();
    chk("dirty_after_writes", 32'(dirty), 32'h1);
    dirty_clr = 1'b1; step(); dirty_clr = 1'b0;
    model_dirty = 1'b0;
    chk("dirty_clr", 32'(dirty), 32'h0);

    // Backup write in idle: one RAM write cycle, ack two cycles after request.
    fork
      bk_op(1'b1, 17'h01234, 8'h5A, 2, 2);
      begin
        @(negedge clk_sys); chk("bkw_we_c0", 32'(bus.ram_we), 32'h0);
        @(negedge clk_sys);
        chk("bkw_we_c1",   32'(bus.ram_we),   32'h1);
        chk("bkw_addr_c1", 32'(bus.ram_addr), 32'h01234);
        chk("bkw_d_c1",    32'(bus.ram_d),    32'h5A);
        @(negedge clk_sys);
        chk("bkw_we_c2",   32'(bus.ram_we),   32'h0);
        chk("bkw_hold_c2", 32'(bus.ram_addr), 32'h01234);
      end
    join
    chk("bkw_mem", 32'(mem[17'h01234]), 32'h5A);
    step();

    // Conflict: CPU read lands on the backup ISSUE cycle.
    fork
      bk_op(1'b0, 17'h00100, '0, 4, 4);
      begin step(); cpu_read(17'h00200); end
    join
    step(); step();

    // Write protect.
    ram_enabled = 1'b0;
    bus.cpu_wr = 1'b1; bus.cpu_addr = 17'h00003; bus.cpu_di = 8'h77;
    @(negedge clk_sys); chk("wp_ram_we", 32'(bus.ram_we), 32'h0);
    step(); bus.cpu_wr = 1'b0; ram_enabled = 1'b1;
    chk("wp_dirty", 32'(dirty), 32'h0);
    chk("wp_mem", 32'(mem[3]), 32'(ref_mem[3]));
    cpu_read(17'h00003); step(); step();

    // Dirty race: set wins over a same-cycle clear.
    dirty_clr = 1'b1;
    cpu_write(17'h00005, 8'h33);
    chk("race_dirty_set", 32'(dirty), 32'h1);
    step(); dirty_clr = 1'b0;
    chk("race_dirty_clr", 32'(dirty), 32'h0);
    model_dirty = 1'b0;

    // Enable drop while a backup read sits in WAIT.
    cpu_write(17'h00007, 8'h44); step();
    bus.bk_req = 1'b1; bus.bk_we = 1'b0; bus.bk_addr = 17'h10005;
    step(); step();
    chk("en_busy_wait", 32'(bus.bk_busy), 32'h1);
    enable = 1'b0;
    step();
    chk("en_busy_idle", 32'(bus.bk_busy), 32'h0);
    bus.bk_req = 1'b0;
    bus.cpu_wr = 1'b1; bus.cpu_addr = 17'h00007; bus.cpu_di = 8'h99;
    @(negedge clk_sys); chk("en_ram_we", 32'(bus.ram_we), 32'h0);
    step(); bus.cpu_wr = 1'b0;
    acks = 0;
    repeat (4) begin @(negedge clk_sys); acks += int'(bus.bk_ack); end
    chk("en_no_ack", 32'(acks), 32'h0);
    chk("en_dirty_hold", 32'(dirty), 32'h1);
    chk("en_mem", 32'(mem[7]), 32'h44);
    step();
    enable = 1'b1;
    step();
    cpu_read(17'h00007); step(); step();

    // Reset in the middle of a backup read.
    bus.bk_req = 1'b1; bus.bk_we = 1'b0; bus.bk_addr = 17'h00010;
    step(); step();
    reset_n = 1'b0;
    #1;
    chk("rmr_busy",   32'(bus.bk_busy), 32'h0);
    chk("rmr_ack",    32'(bus.bk_ack),  32'h0);
    chk("rmr_cpu_do", 32'(bus.cpu_do),  32'hFF);
    step();
    bus.bk_req = 1'b0; reset_n = 1'b1;
    model_dirty = 1'b0;
    acks = 0;
    repeat (5) begin @(negedge clk_sys); acks += int'(bus.bk_ack); end
    chk("rmr_no_ack", 32'(acks), 32'h0);
    step();

    // Randomized mixed traffic.
    fork
      cpu_proc(1500);
      bk_proc();
    join
    repeat (4) step();
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    chk("bk_q_drained",  32'(bk_q.size()),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
